// File: rtl/counter_compare_events.sv
// Compare/event stage: matches count_i against a programmable compare value
// (one-shot or auto-advancing) and queues match timestamps in a small FIFO.
module counter_compare_events #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           count_i,
    input  logic                       cfg_we_i,
    input  logic [WIDTH-1:0]           cfg_cmp_i,
    input  logic [WIDTH-1:0]           cfg_period_i,
    input  logic                       cfg_mode_i,
    input  logic                       disarm_i,
    input  logic                       clr_ovf_i,
    output logic                       evt_valid_o,
    input  logic                       evt_ready_i,
    output logic [WIDTH-1:0]           evt_data_o,
    output logic [$clog2(DEPTH):0]     evt_level_o,
    output logic                       armed_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] cmp_q;
    logic [WIDTH-1:0] period_q;
    logic             mode_q;
    logic             armed_q;
    logic             overflow_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic hit;
    logic full;
    logic pop;
    logic push_en;
    logic drop;

    assign hit     = armed_q && (count_i == cmp_q);
    assign full    = (level_q == LW'(DEPTH));
    assign pop     = (level_q != '0) && evt_ready_i;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_en = hit && (!full || pop);
    assign drop    = hit && full && !pop;

    // Compare configuration and arming; config write beats disarm beats match update.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_q    <= '0;
            period_q <= '0;
            mode_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else if (cfg_we_i) begin
            cmp_q    <= cfg_cmp_i;
            period_q <= cfg_period_i;
            mode_q   <= cfg_mode_i;
            armed_q  <= 1'b1;
        end else if (disarm_i) begin
            armed_q  <= 1'b0;
        end else if (hit) begin
            if (mode_q && (period_q != '0)) begin
                cmp_q <= cmp_q + period_q;
            end else begin
                armed_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= count_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_en && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push_en) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (clr_ovf_i) begin
            overflow_q <= 1'b0;
        end
    end

    assign evt_valid_o = (level_q != '0);
    assign evt_data_o  = evt_valid_o ? mem_q[rd_ptr_q] : '0;
    assign evt_level_o = level_q;
    assign armed_o     = armed_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_counter_compare_events.sv
// Directed bench for counter_compare_events: stimulus pushes expected timestamps,
// a negedge monitor pops and compares each event the consumer accepts.
module tb_counter_compare_events;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] count_i;
    logic             cfg_we_i;
    logic [WIDTH-1:0] cfg_cmp_i;
    logic [WIDTH-1:0] cfg_period_i;
    logic             cfg_mode_i;
    logic             disarm_i;
    logic             clr_ovf_i;
    logic             evt_valid_o;
    logic             evt_ready_i;
    logic [WIDTH-1:0] evt_data_o;
    logic [$clog2(DEPTH):0] evt_level_o;
    logic             armed_o;
    logic             overflow_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [WIDTH-1:0] exp_q [$];

    counter_compare_events #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .count_i      (count_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_cmp_i    (cfg_cmp_i),
        .cfg_period_i (cfg_period_i),
        .cfg_mode_i   (cfg_mode_i),
        .disarm_i     (disarm_i),
        .clr_ovf_i    (clr_ovf_i),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (evt_ready_i),
        .evt_data_o   (evt_data_o),
        .evt_level_o  (evt_level_o),
        .armed_o      (armed_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int c);
        count_i = WIDTH'(c);
        tick();
    endtask

    task automatic cfg(input int cmp, input int period, input logic mode);
        cfg_we_i     = 1'b1;
        cfg_cmp_i    = WIDTH'(cmp);
        cfg_period_i = WIDTH'(period);
        cfg_mode_i   = mode;
        tick();
        cfg_we_i     = 1'b0;
    endtask

    task automatic disarm();
        disarm_i = 1'b1;
        tick();
        disarm_i = 1'b0;
    endtask

    // Monitor: every accepted event must match the oldest expected timestamp.
    always @(negedge clk) begin
        if (evt_valid_o && evt_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'(evt_data_o), 32'hFFFF_FFFF);
            end else begin
                chk("event_data", 32'(evt_data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; count_i = '0; cfg_we_i = 1'b0; cfg_cmp_i = '0; cfg_period_i = '0;
        cfg_mode_i = 1'b0; disarm_i = 1'b0; clr_ovf_i = 1'b0; evt_ready_i = 1'b0;
        tick();
        tick();
        chk("reset_valid", 32'(evt_valid_o), 0);
        chk("reset_level", 32'(evt_level_o), 0);
        chk("reset_armed", 32'(armed_o), 0);
        chk("reset_overflow", 32'(overflow_o), 0);
        chk("reset_data", 32'(evt_data_o), 0);
        rst = 1'b0;

        // One-shot at 10
        evt_ready_i = 1'b1;
        count_i = '0;
        cfg(10, 0, 1'b0);
        chk("t1_armed", 32'(armed_o), 1);
        for (int c = 0; c <= 20; c++) begin
            if (c == 10) exp_q.push_back(8'd10);
            step(c);
            if (c == 10) chk("t1_valid_latency", 32'(evt_valid_o), 1);
        end
        chk("t1_disarmed", 32'(armed_o), 0);

        // Periodic 5 + 7k
        count_i = '0;
        cfg(5, 7, 1'b1);
        for (int c = 0; c <= 30; c++) begin
            if (c == 5 || c == 12 || c == 19 || c == 26) exp_q.push_back(WIDTH'(c));
            step(c);
        end
        chk("t2_armed", 32'(armed_o), 1);
        disarm();
        chk("t2_disarm", 32'(armed_o), 0);

        // Compare value wraps: 250 then 4
        count_i = '0;
        cfg(250, 10, 1'b1);
        for (int c = 240; c <= 266; c++) begin
            if (c == 250) exp_q.push_back(8'd250);
            if (c == 260) exp_q.push_back(8'd4);
            step(c);
        end
        chk("t3_armed", 32'(armed_o), 1);
        disarm();

        // Overflow: 6 matches into 4 slots
        evt_ready_i = 1'b0;
        count_i = '0;
        cfg(100, 2, 1'b1);
        for (int c = 100; c <= 110; c++) begin
            if (c == 100 || c == 102 || c == 104 || c == 106) exp_q.push_back(WIDTH'(c));
            step(c);
        end
        chk("t4_level_full", 32'(evt_level_o), 4);
        chk("t4_overflow", 32'(overflow_o), 1);
        chk("t4_head", 32'(evt_data_o), 100);
        disarm();
        evt_ready_i = 1'b1;
        repeat (6) tick();
        chk("t4_drained", 32'(evt_level_o), 0);
        chk("t4_ovf_sticky", 32'(overflow_o), 1);
        clr_ovf_i = 1'b1;
        tick();
        clr_ovf_i = 1'b0;
        chk("t4_ovf_cleared", 32'(overflow_o), 0);

        // Full FIFO with simultaneous push and pop
        evt_ready_i = 1'b0;
        count_i = '0;
        cfg(50, 1, 1'b1);
        for (int c = 50; c <= 53; c++) begin
            exp_q.push_back(WIDTH'(c));
            step(c);
        end
        chk("t5_full", 32'(evt_level_o), 4);
        evt_ready_i = 1'b1;
        exp_q.push_back(8'd54);
        step(54);
        evt_ready_i = 1'b0;
        count_i = 8'd200;
        chk("t5_level_kept", 32'(evt_level_o), 4);
        chk("t5_no_overflow", 32'(overflow_o), 0);
        disarm();
        evt_ready_i = 1'b1;
        repeat (5) tick();
        chk("t5_drained", 32'(evt_level_o), 0);

        // Config write on a hit cycle
        count_i = '0;
        cfg(70, 0, 1'b0);
        count_i = 8'd70;
        exp_q.push_back(8'd70);
        cfg(80, 0, 1'b0);
        chk("t5_rearmed", 32'(armed_o), 1);
        exp_q.push_back(8'd80);
        step(80);
        chk("t5_new_cmp_fired", 32'(armed_o), 0);
        step(0);

        // Reset mid-run with 3 queued events
        evt_ready_i = 1'b0;
        cfg(30, 1, 1'b1);
        for (int c = 30; c <= 32; c++) step(c);
        chk("t6_level_before", 32'(evt_level_o), 3);
        chk("t6_armed_before", 32'(armed_o), 1);
        rst = 1'b1;
        count_i = 8'd33;
        tick();
        rst = 1'b0;
        chk("t6_valid", 32'(evt_valid_o), 0);
        chk("t6_level", 32'(evt_level_o), 0);
        chk("t6_armed", 32'(armed_o), 0);
        chk("t6_overflow", 32'(overflow_o), 0);
        chk("t6_data", 32'(evt_data_o), 0);
        evt_ready_i = 1'b1;
        count_i = '0;
        repeat (3) tick();
        chk("t6_level_after", 32'(evt_level_o), 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
